// File: rtl/arm_imem_pkg.sv
// -----------------------------------------------------------------------------
// arm_imem_pkg
// Shared types and constants for the instruction-memory responder.
//   imem_state_t  : responder FSM states (IDLE, WAIT, RESP)
//   IMEM_ERR_DATA : word returned with resp_err=1
//   ARM_NOP       : MOV r0,r0 encoding, handy for filling program memory
//   imem_idx_w()  : word-index width for a given DEPTH (at least 1 bit)
// -----------------------------------------------------------------------------
package arm_imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  localparam logic [31:0] IMEM_ERR_DATA = 32'h0000_0000;
  localparam logic [31:0] ARM_NOP       = 32'hE1A0_0000;

  function automatic int unsigned imem_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// -----------------------------------------------------------------------------
// inst_mem_responder_if
// Fetch request/response channels, flush cancel and program-load port.
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1; the sender holds its payload stable while
// valid=1 and ready=0.
//   master : fetch stage / bench side (drives requests, loads, cancel)
//   slave  : responder side (drives req_ready and the resp_* signals)
// -----------------------------------------------------------------------------
interface inst_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              cancel;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic [ADDR_W-1:0] resp_addr;
  logic              resp_err;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;

  modport master (
    output req_valid, req_addr, cancel, resp_ready, load_we, load_addr, load_data,
    input  req_ready, resp_valid, resp_data, resp_addr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, cancel, resp_ready, load_we, load_addr, load_data,
    output req_ready, resp_valid, resp_data, resp_addr, resp_err
  );
endinterface

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// DEPTH x 32 instruction storage. Synchronous write, combinational read.
// A write to the word being read in the same cycle is forwarded to rdata_o so
// a sample taken on that edge sees the new word (write-first).
//   clk     : clock
//   we_i    : write enable (caller has already filtered illegal addresses)
//   waddr_i : write word index
//   wdata_i : write data
//   raddr_i : read word index
//   rdata_o : read data
// -----------------------------------------------------------------------------
module imem_array
  import arm_imem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = imem_idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  // Contents survive reset on purpose: a reset must not erase a loaded program.
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];

endmodule

// File: rtl/inst_mem_responder.sv
// -----------------------------------------------------------------------------
// inst_mem_responder
// Fetch-side instruction memory. Accepts one request at a time, returns the
// word LATENCY cycles after the request handshake and holds it until the
// fetch stage takes it. cancel flushes any in-flight fetch.
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   bus          : request/response/cancel/load channels (slave modport)
//   dbg_state_o  : current FSM state
//   stat_req_cnt, stat_cancel_cnt : saturating counters, only present when
//                  IMEM_STATS_EN is defined
// Optional feature macro: IMEM_STATS_EN
// -----------------------------------------------------------------------------
module inst_mem_responder
  import arm_imem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_mem_responder_if.slave  bus,
  output imem_state_t          dbg_state_o
`ifdef IMEM_STATS_EN
  ,
  output logic [15:0]          stat_req_cnt,
  output logic [15:0]          stat_cancel_cnt
`endif
);

  localparam int IDX_W = imem_idx_w(DEPTH);

  imem_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;

  logic              req_ready;
  logic              req_hs;
  logic              sample;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bad;
  logic [31:0]       rd_data;
  logic              wr_en;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] widx;
    widx = a >> 2;
    return (a[1:0] != 2'b00) || (widx >= ADDR_W'(DEPTH));
  endfunction

  // req_ready is gated by rst so it reads 0 for the whole reset pulse even
  // though the state register already sits in IDLE.
  assign req_ready = rst && (state_q == IDLE) && !bus.cancel;
  assign req_hs    = bus.req_valid && req_ready;

  // With LATENCY==1 the sample happens on the handshake edge itself, so the
  // read address must come straight from the request port while in IDLE.
  assign rd_addr = (state_q == IDLE) ? bus.req_addr : addr_q;
  assign rd_bad  = addr_bad(rd_addr);
  assign wr_en   = bus.load_we && !addr_bad(bus.load_addr);

  imem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (bus.load_addr[IDX_W+1:2]),
    .wdata_i (bus.load_data),
    .raddr_i (rd_addr[IDX_W+1:2]),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    sample  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          addr_d = bus.req_addr;
          cnt_d  = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            sample  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          sample  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // cancel wins over a simultaneous resp_ready: the word is dropped.
        if (bus.cancel || bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (sample) begin
      err_d  = rd_bad;
      data_d = rd_bad ? IMEM_ERR_DATA : rd_data;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = data_q;
  assign bus.resp_addr  = addr_q;
  assign bus.resp_err   = err_q;
  assign dbg_state_o    = state_q;

`ifdef IMEM_STATS_EN
  logic [15:0] stat_req_q, stat_cancel_q;
  logic        cancel_hit;

  assign cancel_hit = bus.cancel && ((state_q == WAIT) || (state_q == RESP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_req_q    <= '0;
      stat_cancel_q <= '0;
    end else begin
      if (req_hs && (stat_req_q != 16'hFFFF))
        stat_req_q <= stat_req_q + 16'd1;
      if (cancel_hit && (stat_cancel_q != 16'hFFFF))
        stat_cancel_q <= stat_cancel_q + 16'd1;
    end
  end

  assign stat_req_cnt    = stat_req_q;
  assign stat_cancel_cnt = stat_cancel_q;
`endif

endmodule

// File: tb/tb_inst_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_responder
// Directed bench for inst_mem_responder (DEPTH=256, ADDR_W=32, LATENCY=2).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
// Honours IMEM_STATS_EN when defined.
// -----------------------------------------------------------------------------
module tb_inst_mem_responder;
  import arm_imem_pkg::*;

  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 32;
  localparam int LATENCY = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();
  imem_state_t dbg_state;
`ifdef IMEM_STATS_EN
  logic [15:0] stat_req_cnt;
  logic [15:0] stat_cancel_cnt;
`endif

  inst_mem_responder #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
`ifdef IMEM_STATS_EN
    ,
    .stat_req_cnt    (stat_req_cnt),
    .stat_cancel_cnt (stat_cancel_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    bus.load_we   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick();
    bus.load_we   = 1'b0;
  endtask

  // Presents a request and completes the handshake on the next edge.
  task automatic do_req(input string tag, input logic [31:0] a);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    #1;
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Called right after the handshake edge: checks the exact latency and the
  // response fields against the head of exp_q.
  task automatic expect_resp(input string tag, input logic [31:0] a, input logic e);
    logic [31:0] exp_d;
    chk({tag, "_valid_n1"}, 32'(bus.resp_valid), 32'd0);
    tick();
    chk({tag, "_valid_n2"}, 32'(bus.resp_valid), 32'd0);
    tick();
    exp_d = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_data"},  bus.resp_data, exp_d);
    chk({tag, "_addr"},  bus.resp_addr, a);
    chk({tag, "_err"},   32'(bus.resp_err), 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.cancel     = 1'b0;
    bus.resp_ready = 1'b1;
    bus.load_we    = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;

    // Reset values
    tick();
    chk("rst_req_ready",  32'(bus.req_ready),  32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data",  bus.resp_data,       32'd0);
    chk("rst_resp_addr",  bus.resp_addr,       32'd0);
    chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
    chk("rst_state",      32'(dbg_state),      32'(IDLE));
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    tick();

    // Program load
    load_word(32'h14, 32'hE3A01001);
    load_word(32'h20, 32'h1111_2222);
    load_word(32'h0,  ARM_NOP);

    // Basic fetch, resp_ready held high
    exp_q.push_back(32'hE3A01001);
    do_req("f14", 32'h14);
    chk("f14_state_wait", 32'(dbg_state), 32'(WAIT));
    expect_resp("f14", 32'h14, 1'b0);
    chk("f14_req_ready_resp", 32'(bus.req_ready), 32'd0);
    tick();
    chk("f14_valid_drop", 32'(bus.resp_valid), 32'd0);
    chk("f14_state_idle", 32'(dbg_state), 32'(IDLE));

    // Back-pressure: response held for 4 cycles
    bus.resp_ready = 1'b0;
    exp_q.push_back(32'hE3A01001);
    do_req("bp", 32'h14);
    expect_resp("bp", 32'h14, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_hold_data",  bus.resp_data, 32'hE3A01001);
      chk("bp_hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(bus.resp_valid), 32'd0);
    chk("bp_req_ready",  32'(bus.req_ready),  32'd1);

    // Second word readable
    exp_q.push_back(32'h1111_2222);
    do_req("f20", 32'h20);
    expect_resp("f20", 32'h20, 1'b0);
    tick();

    // Cancel in WAIT: no response, following fetch is unaffected
    do_req("cw", 32'h20);
    bus.cancel = 1'b1;
    #1;
    chk("cw_req_ready_cancel", 32'(bus.req_ready), 32'd0);
    tick();
    bus.cancel = 1'b0;
    chk("cw_state_idle", 32'(dbg_state), 32'(IDLE));
    chk("cw_valid0", 32'(bus.resp_valid), 32'd0);
    tick();
    chk("cw_valid1", 32'(bus.resp_valid), 32'd0);
`ifdef IMEM_STATS_EN
    chk("stat_cancel_1", 32'(stat_cancel_cnt), 32'd1);
`endif
    exp_q.push_back(32'hE3A01001);
    do_req("after_cw", 32'h14);
    expect_resp("after_cw", 32'h14, 1'b0);
    tick();

    // Misaligned and out-of-range addresses
    exp_q.push_back(32'h0);
    do_req("mis", 32'h401);
    expect_resp("mis", 32'h401, 1'b1);
    tick();
    exp_q.push_back(32'h0);
    do_req("oor", 32'h400);
    expect_resp("oor", 32'h400, 1'b1);
    tick();

    // Write-first on the sample edge, later load leaves held word alone,
    // then cancel overrides resp_ready in RESP.
    bus.resp_ready = 1'b0;
    do_req("wf", 32'h14);
    tick();
    bus.load_we   = 1'b1;
    bus.load_addr = 32'h14;
    bus.load_data = ARM_NOP;
    tick();
    bus.load_we = 1'b0;
    chk("wf_valid", 32'(bus.resp_valid), 32'd1);
    chk("wf_data",  bus.resp_data, ARM_NOP);
    load_word(32'h14, 32'h1234_5678);
    chk("wf_hold_data", bus.resp_data, ARM_NOP);
    bus.cancel     = 1'b1;
    bus.resp_ready = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("cr_valid",  32'(bus.resp_valid), 32'd0);
    chk("cr_state",  32'(dbg_state), 32'(IDLE));
    tick();

    // Reset in the middle of WAIT
    do_req("rw", 32'h20);
    rst = 1'b0;
    #1;
    chk("rw_state",      32'(dbg_state),      32'(IDLE));
    chk("rw_req_ready",  32'(bus.req_ready),  32'd0);
    chk("rw_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rw_resp_addr",  bus.resp_addr,       32'd0);
    chk("rw_resp_data",  bus.resp_data,       32'd0);
`ifdef IMEM_STATS_EN
    chk("rw_stat_req",    32'(stat_req_cnt),    32'd0);
    chk("rw_stat_cancel", 32'(stat_cancel_cnt), 32'd0);
`endif
    tick();
    rst = 1'b1;
    #1;
    chk("rw_req_ready_rel", 32'(bus.req_ready), 32'd1);
    tick();
    chk("rw_no_resp", 32'(bus.resp_valid), 32'd0);

    exp_q.push_back(32'h1234_5678);
    do_req("post_rst", 32'h14);
    expect_resp("post_rst", 32'h14, 1'b0);
    tick();
`ifdef IMEM_STATS_EN
    chk("stat_req_after", 32'(stat_req_cnt), 32'd1);
`endif
    exp_q.push_back(ARM_NOP);
    do_req("f0", 32'h0);
    expect_resp("f0", 32'h0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
